// File: rtl/peripheral_tl_pkg.sv
// Shared AHB-Lite definitions: transfer type, size and response encodings,
// the AHB memory slave FSM state type, and byte-lane helper functions.
package peripheral_tl_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    AHB_SLV_IDLE = 3'd0,
    AHB_SLV_WAIT = 3'd1,
    AHB_SLV_DATA = 3'd2,
    AHB_SLV_ERR1 = 3'd3,
    AHB_SLV_ERR2 = 3'd4
  } ahb_slv_state_e;

  // Address bits below the transfer size; anything wider than DWORD
  // covers the whole 8-byte word.
  function automatic logic [2:0] size_low_mask(input logic [2:0] size);
    logic [2:0] mask;
    if (size >= HSIZE_DWORD) begin
      mask = 3'b111;
    end else begin
      mask = (3'b001 << size) - 3'b001;
    end
    return mask;
  endfunction

  // True when byte lane 'lane' belongs to the naturally aligned block that
  // contains 'offset' for the given size (misaligned offsets align down).
  function automatic logic lane_sel(input logic [2:0] size,
                                    input logic [2:0] offset,
                                    input logic [2:0] lane);
    logic [2:0] keep;
    keep = ~size_low_mask(size);
    return (lane & keep) == (offset & keep);
  endfunction

endpackage

// File: rtl/peripheral_ahb_slave_ram.sv
// Byte-enabled word storage: one synchronous write port with per-lane
// enables and one combinational read port. Contents are never reset.
module peripheral_ahb_slave_ram #(
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8,
  parameter int DATA_W = 64
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Commit the enabled byte lanes of the write word.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (we_i && be_i[i]) begin
        mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/peripheral_ahb_slave_mem.sv
// AHB-Lite memory slave with configurable wait states.
// Optional feature macro: PERIPHERAL_AHB_SLAVE_ERR_EN -- when defined,
// out-of-range, oversize and misaligned transfers get a two-cycle ERROR
// response; otherwise addresses wrap, misaligned addresses align down and
// oversize transfers behave as DWORD. Words are 8 bytes wide.
module peripheral_ahb_slave_mem
  import peripheral_tl_pkg::*;
#(
  parameter int HADDR_SIZE  = 64,
  parameter int HDATA_SIZE  = 64,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int LANES = HDATA_SIZE / 8;
  localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [1:0]       rst_sync_q;
  logic             rst_core_n_s;

  ahb_slv_state_e   state_q, state_d, enter_s;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       off_q, off_d;
  logic [2:0]       size_q, size_d;
  logic             write_q, write_d;

  logic             take_s;
  logic             open_s;
  logic             hreadyout_s;
  logic             rd_sel_s;
  logic             we_s;
  logic [LANES-1:0] be_s;
  logic [HDATA_SIZE-1:0] ram_rdata_s;
  logic             unused_s;

  // Bus sideband inputs carry no meaning for this slave.
  assign unused_s = ^{HBURST, HPROT, HMASTLOCK, HADDR};

  // Reset asserts immediately but is released only on a clock edge.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_core_n_s = rst_sync_q[1];

  // A new address phase is only taken where the slave can start a data phase.
  assign open_s = (state_q == AHB_SLV_IDLE) || (state_q == AHB_SLV_DATA)
`ifdef PERIPHERAL_AHB_SLAVE_ERR_EN
               || (state_q == AHB_SLV_ERR2)
`endif
               ;
  assign take_s = open_s && HSEL && HREADY &&
                  ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

`ifdef PERIPHERAL_AHB_SLAVE_ERR_EN
  localparam logic [HADDR_SIZE-1:0] MEM_BYTES = HADDR_SIZE'(MEM_DEPTH * 8);
  logic err_s;
  assign err_s = (HADDR >= MEM_BYTES) || (HSIZE > HSIZE_DWORD) ||
                 ((HADDR[2:0] & size_low_mask(HSIZE)) != 3'b000);
  assign enter_s = err_s ? AHB_SLV_ERR1 :
                   ((WAIT_STATES > 0) ? AHB_SLV_WAIT : AHB_SLV_DATA);
`else
  assign enter_s = (WAIT_STATES > 0) ? AHB_SLV_WAIT : AHB_SLV_DATA;
`endif

  // State, wait counter and registered address-phase controls.
  always_ff @(posedge HCLK or negedge rst_core_n_s) begin
    if (!rst_core_n_s) begin
      state_q    <= AHB_SLV_IDLE;
      wait_cnt_q <= 4'd0;
      idx_q      <= {IDX_W{1'b0}};
      off_q      <= 3'b000;
      size_q     <= 3'b000;
      write_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      idx_q      <= idx_d;
      off_q      <= off_d;
      size_q     <= size_d;
      write_q    <= write_d;
    end
  end

  // Next state, wait counting and capture of accepted address phases.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = 4'd0;
    idx_d      = idx_q;
    off_d      = off_q;
    size_d     = size_q;
    write_d    = write_q;
    if (take_s) begin
      idx_d   = HADDR[IDX_W+2:3];
      off_d   = HADDR[2:0];
      size_d  = HSIZE;
      write_d = HWRITE;
    end else begin
      write_d = write_q;
    end
    case (state_q)
      AHB_SLV_IDLE, AHB_SLV_DATA: begin
        state_d = take_s ? enter_s : AHB_SLV_IDLE;
      end
      AHB_SLV_WAIT: begin
        if (wait_cnt_q == WS_LAST) begin
          state_d = AHB_SLV_DATA;
        end else begin
          state_d    = AHB_SLV_WAIT;
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
`ifdef PERIPHERAL_AHB_SLAVE_ERR_EN
      AHB_SLV_ERR1: begin
        state_d = AHB_SLV_ERR2;
      end
      AHB_SLV_ERR2: begin
        state_d = take_s ? enter_s : AHB_SLV_IDLE;
      end
`endif
      default: begin
        state_d = AHB_SLV_IDLE;
      end
    endcase
  end

`ifdef PERIPHERAL_AHB_SLAVE_ERR_EN
  logic hresp_s;
`endif

  // Bus-facing handshake and read-data select decoded from the state.
  always_comb begin
    hreadyout_s = 1'b1;
    rd_sel_s    = 1'b0;
`ifdef PERIPHERAL_AHB_SLAVE_ERR_EN
    hresp_s     = HRESP_OKAY;
`endif
    case (state_q)
      AHB_SLV_IDLE: begin
        hreadyout_s = 1'b1;
      end
      AHB_SLV_WAIT: begin
        hreadyout_s = 1'b0;
      end
      AHB_SLV_DATA: begin
        rd_sel_s = ~write_q;
      end
`ifdef PERIPHERAL_AHB_SLAVE_ERR_EN
      AHB_SLV_ERR1: begin
        hreadyout_s = 1'b0;
        hresp_s     = HRESP_ERROR;
      end
      AHB_SLV_ERR2: begin
        hresp_s = HRESP_ERROR;
      end
`endif
      default: begin
        hreadyout_s = 1'b1;
      end
    endcase
  end

  assign HREADYOUT = hreadyout_s;
`ifdef PERIPHERAL_AHB_SLAVE_ERR_EN
  assign HRESP = hresp_s;
`else
  assign HRESP = HRESP_OKAY;
`endif
  assign HRDATA = rd_sel_s ? ram_rdata_s : {HDATA_SIZE{1'b0}};

  // Write data is committed at the edge that closes a write data phase.
  assign we_s = (state_q == AHB_SLV_DATA) && write_q;

  // Byte lanes touched by the registered size and low address bits.
  always_comb begin
    be_s = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      be_s[i] = lane_sel(size_q, off_q, 3'(i));
    end
  end

  peripheral_ahb_slave_ram #(
    .DEPTH  (MEM_DEPTH),
    .IDX_W  (IDX_W),
    .DATA_W (HDATA_SIZE)
  ) u_ram (
    .clk_i   (HCLK),
    .we_i    (we_s),
    .be_i    (be_s),
    .waddr_i (idx_q),
    .wdata_i (HWDATA),
    .raddr_i (idx_q),
    .rdata_o (ram_rdata_s)
  );

endmodule

// File: tb/tb_peripheral_ahb_slave_mem.sv
// Self-checking bench for peripheral_ahb_slave_mem: one instance with no
// wait states, one with two, each checked against a word-array model.
// Expectations follow PERIPHERAL_AHB_SLAVE_ERR_EN when it is defined.
module tb_peripheral_ahb_slave_mem;

  localparam int DEPTH = 256;
`ifdef PERIPHERAL_AHB_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        hclk;
  logic        hresetn;
  logic        hsel      [2];
  logic [63:0] haddr     [2];
  logic [63:0] hwdata    [2];
  logic [63:0] hrdata    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [1:0]  htrans    [2];
  logic        hreadyout [2];
  logic        hresp     [2];

  int          n_checks;
  int          n_errors;
  logic [63:0] model [2][DEPTH];

  logic        op_wr   [8];
  logic [63:0] op_addr [8];
  logic [63:0] op_data [8];

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  peripheral_ahb_slave_mem #(.HADDR_SIZE(64), .HDATA_SIZE(64), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u_dut_ws0 (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel[0]), .HADDR(haddr[0]), .HWDATA(hwdata[0]),
    .HRDATA(hrdata[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(3'b000), .HPROT(4'b0011),
    .HTRANS(htrans[0]), .HMASTLOCK(1'b0), .HREADY(hreadyout[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]));

  peripheral_ahb_slave_mem #(.HADDR_SIZE(64), .HDATA_SIZE(64), .MEM_DEPTH(DEPTH), .WAIT_STATES(2)) u_dut_ws2 (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel[1]), .HADDR(haddr[1]), .HWDATA(hwdata[1]),
    .HRDATA(hrdata[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(3'b001), .HPROT(4'b0001),
    .HTRANS(htrans[1]), .HMASTLOCK(1'b0), .HREADY(hreadyout[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]));

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_err(input logic [63:0] a, input logic [2:0] sz);
    bit bad;
    bad = (a >= 64'(DEPTH * 8)) || (sz > 3'd3) || ((a % (64'd1 << sz)) != 64'd0);
    return bad && ERR_EN;
  endfunction

  function automatic int ref_idx(input logic [63:0] a);
    return int'((a / 64'd8) % 64'(DEPTH));
  endfunction

  // Merge the bytes a transfer of this size at this address touches.
  task automatic ref_write(input int d, input logic [63:0] a, input logic [2:0] sz, input logic [63:0] wd);
    int nb, off, idx;
    logic [63:0] w;
    nb  = (sz > 3'd3) ? 8 : (1 << sz);
    off = (int'(a % 64'd8) / nb) * nb;
    idx = ref_idx(a);
    w   = model[d][idx];
    for (int b = off; b < off + nb; b++) w[b*8 +: 8] = wd[b*8 +: 8];
    model[d][idx] = w;
  endtask

  // One isolated transfer: address phase, then the data phase to completion.
  task automatic xfer(input int d, input bit wr, input logic [63:0] a, input logic [2:0] sz,
                      input logic [63:0] wd, input string tag, output logic [63:0] rd);
    bit   e;
    int   lows, exp_lows, idx;
    logic first_resp;
    e        = ref_err(a, sz);
    idx      = ref_idx(a);
    exp_lows = e ? 1 : ((d == 1) ? 2 : 0);
    @(negedge hclk);
    hsel[d] = 1'b1; htrans[d] = 2'b10; haddr[d] = a; hwrite[d] = wr; hsize[d] = sz;
    @(negedge hclk);
    hsel[d] = 1'b0; htrans[d] = 2'b00; hwdata[d] = wd; haddr[d] = {$urandom, $urandom};
    lows = 0; first_resp = 1'b0;
    while (hreadyout[d] !== 1'b1 && lows < 32) begin
      if (lows == 0) first_resp = hresp[d];
      lows++;
      @(negedge hclk);
    end
    check_val({tag, "_lows"}, 64'(lows), 64'(exp_lows));
    if (lows > 0) check_val({tag, "_resp_wait"}, 64'(first_resp), 64'(e));
    check_val({tag, "_resp"}, 64'(hresp[d]), 64'(e));
    rd = hrdata[d];
    if (e) check_val({tag, "_rdata_err"}, rd, 64'd0);
    else if (!wr) check_val({tag, "_rdata"}, rd, model[d][idx]);
    if (wr && !e) ref_write(d, a, sz, wd);
  endtask

  // Pipelined DWORD transfers on the zero-wait instance, one per cycle.
  task automatic pipe_run(input int n);
    @(negedge hclk);
    hsel[0] = 1'b1; htrans[0] = 2'b10; haddr[0] = op_addr[0]; hwrite[0] = op_wr[0]; hsize[0] = 3'd3;
    for (int k = 0; k < n; k++) begin
      @(negedge hclk);
      check_val("b2b_ready", 64'(hreadyout[0]), 64'd1);
      if (!op_wr[k]) check_val("b2b_rdata", hrdata[0], model[0][ref_idx(op_addr[k])]);
      else ref_write(0, op_addr[k], 3'd3, op_data[k]);
      hwdata[0] = op_wr[k] ? op_data[k] : 64'd0;
      if (k + 1 < n) begin
        htrans[0] = 2'b11; haddr[0] = op_addr[k+1]; hwrite[0] = op_wr[k+1];
      end else begin
        hsel[0] = 1'b0; htrans[0] = 2'b00;
      end
    end
    @(negedge hclk);
  endtask

  initial begin
    logic [63:0] rd, a, old, pa, pb;
    logic [2:0]  sz;
    int          d;
    n_checks = 0; n_errors = 0;
    hresetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      hsel[i] = 1'b0; htrans[i] = 2'b00; haddr[i] = 64'd0;
      hwdata[i] = 64'd0; hwrite[i] = 1'b0; hsize[i] = 3'd0;
    end
    repeat (3) @(negedge hclk);
    for (int i = 0; i < 2; i++) begin
      check_val("reset_ready", 64'(hreadyout[i]), 64'd1);
      check_val("reset_resp", 64'(hresp[i]), 64'd0);
      check_val("reset_rdata", hrdata[i], 64'd0);
    end
    hresetn = 1'b1;
    repeat (4) @(negedge hclk);

    // Give every word a known value in both instances.
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < DEPTH; w++)
        xfer(i, 1'b1, 64'(w * 8), 3'd3, {$urandom, $urandom}, "init", rd);

    // DWORD write/read and a byte overwrite on the zero-wait instance.
    xfer(0, 1'b1, 64'h10, 3'd3, 64'h1122334455667788, "dw_wr", rd);
    xfer(0, 1'b0, 64'h10, 3'd3, 64'd0, "dw_rd", rd);
    check_val("dw_value", rd, 64'h1122334455667788);
    xfer(0, 1'b1, 64'h13, 3'd0, 64'h00000000AB000000, "byte_wr", rd);
    xfer(0, 1'b0, 64'h10, 3'd3, 64'd0, "byte_rd", rd);
    check_val("byte_value", rd, 64'h11223344AB667788);

    // Two wait states before the read data is valid.
    xfer(1, 1'b1, 64'h10, 3'd3, 64'hCAFEF00D12345678, "ws_wr", rd);
    xfer(1, 1'b0, 64'h10, 3'd3, 64'd0, "ws_rd", rd);
    check_val("ws_value", rd, 64'hCAFEF00D12345678);

    // Out-of-range, misaligned and oversize transfers.
    xfer(0, 1'b1, 64'h800, 3'd3, 64'hDEADBEEFDEADBEEF, "oob_wr", rd);
    xfer(0, 1'b0, 64'h0, 3'd3, 64'd0, "oob_chk", rd);
    xfer(0, 1'b0, 64'h12, 3'd2, 64'd0, "mis_rd", rd);
    xfer(0, 1'b1, 64'h22, 3'd1, 64'h0000000055AA0000, "mis_wr", rd);
    xfer(0, 1'b0, 64'h20, 3'd3, 64'd0, "mis_chk", rd);
    xfer(1, 1'b1, 64'h28, 3'd5, 64'h0123456789ABCDEF, "big_wr", rd);
    xfer(1, 1'b0, 64'h28, 3'd3, 64'd0, "big_chk", rd);

    // Back-to-back traffic including read-after-write of the same word.
    for (int r = 0; r < 4; r++) begin
      pa = 64'($urandom_range(0, DEPTH - 1)) * 64'd8;
      pb = 64'($urandom_range(0, DEPTH - 1)) * 64'd8;
      op_wr[0] = 1'b1; op_addr[0] = pa;
      op_wr[1] = 1'b0; op_addr[1] = pa;
      op_wr[2] = 1'b1; op_addr[2] = pb;
      op_wr[3] = 1'b0; op_addr[3] = pa;
      op_wr[4] = 1'b0; op_addr[4] = pb;
      op_wr[5] = 1'b1; op_addr[5] = pb;
      op_wr[6] = 1'b0; op_addr[6] = pb;
      op_wr[7] = 1'b0; op_addr[7] = 64'($urandom_range(0, DEPTH - 1)) * 64'd8;
      for (int k = 0; k < 8; k++) op_data[k] = {$urandom, $urandom};
      pipe_run(8);
    end

    // Random isolated transfers on either instance.
    for (int t = 0; t < 300; t++) begin
      d  = int'($urandom_range(0, 1));
      a  = ($urandom_range(0, 9) < 8) ? 64'($urandom_range(0, DEPTH * 8 - 1))
                                      : 64'($urandom_range(0, DEPTH * 16 - 1));
      sz = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      if ($urandom_range(0, 1) == 1 && sz <= 3'd3) a = a & ~((64'd1 << sz) - 64'd1);
      xfer(d, 1'($urandom_range(0, 1)), a, sz, {$urandom, $urandom}, "rand", rd);
    end

    // Reset during the wait states of a write abandons the write.
    a   = 64'h40;
    old = model[1][ref_idx(a)];
    @(negedge hclk);
    hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = a; hwrite[1] = 1'b1; hsize[1] = 3'd3;
    @(negedge hclk);
    hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = ~old;
    check_val("rst_in_wait", 64'(hreadyout[1]), 64'd0);
    #2 hresetn = 1'b0;
    #1;
    check_val("rst_async_ready", 64'(hreadyout[1]), 64'd1);
    check_val("rst_async_resp", 64'(hresp[1]), 64'd0);
    check_val("rst_async_rdata", hrdata[1], 64'd0);
    repeat (3) @(negedge hclk);
    hresetn = 1'b1;
    repeat (4) @(negedge hclk);
    xfer(1, 1'b0, a, 3'd3, 64'd0, "rst_after", rd);
    check_val("rst_word_kept", rd, old);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/peripheral_ahb_slave_mem.md
PERIPHERAL_AHB_SLAVE_MEM -- requirements
Module: peripheral_ahb_slave_mem

Interface
REQ-001 SHALL have parameter HADDR_SIZE, default 64, address width in bits.
REQ-002 SHALL have parameter HDATA_SIZE, default 64, data width in bits.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, memory depth in HDATA_SIZE-bit words.
REQ-004 SHALL have parameter WAIT_STATES, default 0, range 0..15, HREADYOUT-low cycles per OKAY data phase.
REQ-005 SHALL have ports, clock and reset first:
- HCLK  input  1  clock.
- HRESETn  input  1  asynchronous active-low reset.
- HSEL  input  1  slave select.
- HADDR  input  HADDR_SIZE  byte address.
- HWDATA  input  HDATA_SIZE  write data.
- HRDATA  output  HDATA_SIZE  read data.
- HWRITE  input  1  1 = write.
- HSIZE  input  3  transfer size.
- HBURST  input  3  burst type; accepted, not decoded.
- HPROT  input  4  protection; accepted, not decoded.
- HTRANS  input  2  transfer type.
- HMASTLOCK  input  1  lock; ignored.
- HREADY  input  1  bus-level ready from interconnect.
- HREADYOUT  output  1  slave ready.
- HRESP  output  1  response.

Function
REQ-006 SHALL accept an address phase only on a rising HCLK edge with HSEL=1, HREADY=1 and HTRANS NONSEQ or SEQ; it SHALL register HADDR, HWRITE and HSIZE at that edge.
REQ-007 SHALL answer IDLE, BUSY or unselected transfers with HREADYOUT=1, HRESP=OKAY and no memory access.
REQ-008 SHALL implement FSM states IDLE, WAIT, DATA, ERR1, ERR2:
- IDLE: accepted OKAY transfer -> WAIT if WAIT_STATES>0, else DATA.
- IDLE: accepted erroneous transfer -> ERR1.
- WAIT: counts WAIT_STATES cycles, then -> DATA.
- DATA: acceptance of a new transfer in the same cycle re-enters per the IDLE rules; otherwise -> IDLE.
- ERR1 -> ERR2.
- ERR2: follows the DATA rules.
REQ-009 SHALL drive HREADYOUT=0 in WAIT and ERR1, and HREADYOUT=1 in IDLE, DATA and ERR2.
REQ-010 SHALL drive HRESP=ERROR in ERR1 and ERR2, and OKAY otherwise.
REQ-011 Read: SHALL present the word at the registered address on HRDATA combinationally during the DATA cycle, with all byte lanes driven.
REQ-012 Write: SHALL commit HWDATA at the edge ending the DATA cycle, writing only the byte lanes selected by HSIZE and the registered address bits [2:0].
REQ-013 A write data phase followed immediately by a read of the same address SHALL return the newly written data.
REQ-014 The memory index SHALL be registered address bits [log2(MEM_DEPTH)+2:3].
REQ-015 An erroneous transfer SHALL NOT modify memory; HRDATA during ERR1/ERR2 SHALL be 0.
REQ-016 Transfers presented during ERR1 SHALL be ignored; the master is required to drive IDLE in ERR2 per AHB-Lite.
REQ-017 Back-to-back zero-wait transfers SHALL sustain one transfer per cycle.

Reset
REQ-018 While HRESETn=0, outputs SHALL be HREADYOUT=1, HRESP=OKAY, HRDATA=0, with the FSM in IDLE and the wait counter at 0.
REQ-019 Reset SHALL be applied asynchronously on assertion and released synchronously to HCLK.
REQ-020 Memory contents SHALL NOT be reset.
REQ-021 A transfer in flight at reset SHALL be abandoned without a write.

Configuration
REQ-022 With PERIPHERAL_AHB_SLAVE_ERR_EN defined, a transfer SHALL be erroneous if any of these holds:
- address >= MEM_DEPTH*8;
- HSIZE > DWORD;
- address not aligned to HSIZE.
REQ-023 Without PERIPHERAL_AHB_SLAVE_ERR_EN:
- ERR1/ERR2 SHALL be absent and HRESP SHALL be tied OKAY;
- address SHALL wrap modulo MEM_DEPTH words;
- misaligned addresses SHALL be aligned down to HSIZE;
- HSIZE > DWORD SHALL be treated as DWORD.

Structure
REQ-024 HTRANS, HSIZE and HRESP encodings SHALL come from the shared AHB-Lite package peripheral_tl_pkg.
REQ-025 The FSM state enum typedef SHALL be added to peripheral_tl_pkg.
REQ-026 The byte-enabled storage array SHALL be a sub-module, peripheral_ahb_slave_ram (one write port, one combinational read port).

Verification
REQ-027 The bench SHALL cover, with WAIT_STATES=0:
- Write DWORD 0x1122334455667788 to 0x10, then read 0x10 -> HRDATA=0x1122334455667788, HREADYOUT=1 in every data phase.
- Byte write 0xAB to 0x13 over that word, then read 0x10 -> 0x11223344AB667788.
REQ-028 The bench SHALL cover, with WAIT_STATES=2: read 0x10 -> HREADYOUT=0 for exactly 2 cycles, then 1 with data valid.
REQ-029 The bench SHALL cover, with PERIPHERAL_AHB_SLAVE_ERR_EN defined and MEM_DEPTH=256:
- Write to 0x800 -> (HREADYOUT,HRESP) = (0,1) then (1,1), and memory is unchanged.
- WORD read at 0x12 -> the same two-cycle error.
REQ-030 The bench SHALL cover: assert HRESETn mid-wait of a write -> HREADYOUT=1 and HRESP=0 immediately, and the target word is unchanged after reset.
